fifo_fwft_adapter: RTL and testbench
====================================

# fifo_fwft_adapter

Read-side adapter that drains a standard-read FIFO (`read`/`dout`/`empty`, one-cycle read latency) and presents the data as a first-word-fall-through valid/ready stream. It sits directly downstream of the async FIFO, in the read-clock domain, so consumers can use a plain handshake without tracking FIFO read latency. A two-entry output buffer with credit-based read issue sustains one word per cycle under continuous `out_ready`. It absorbs back-pressure without losing or duplicating data.

## Interface
Parameters:
- `DWIDTH`, 32, data width; must match the FIFO `DWIDTH`.

Ports:
- `clk`  in  1  single clock; the FIFO read clock.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_read`  out  1  read strobe to the FIFO; one word per cycle asserted.
- `fifo_dout`  in  DWIDTH  FIFO read data; valid the cycle after `fifo_read`.
- `fifo_empty`  in  1  FIFO empty flag.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_data`  out  DWIDTH  head-of-stream word.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.

Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.

## Operation
- **Storage:** two registers, `head` and `skid`.
- **Occupancy state machine:** EMPTY (0 words), ONE (word in `head`), TWO (`head` and `skid` both full).
- **In-flight tracking:** bit `inflight` is set in the cycle after `fifo_read` is asserted. In that cycle `fifo_dout` must be captured.
- **Pop:** `pop = out_valid && out_ready`.
- **Read issue:** `fifo_read = !rst && !fifo_empty && (occ + inflight - pop < 2)`.
  - `occ` is 0, 1 or 2 from the state.
  - Use 2-bit-plus-one arithmetic; no wrap.
  - Never assert `fifo_read` while `fifo_empty=1`.
- **Capture when `inflight=1`:**
  - EMPTY, or ONE with `pop`: the word goes to `head`.
  - ONE without `pop`: the word goes to `skid`.
  - TWO is unreachable with `inflight=1`, because the credit rule forbids it.
- **Pop handling:** on `pop` in TWO, `skid` moves to `head`. A simultaneous pop and capture in TWO cannot occur.
- **State transitions (per cycle, with `cap = inflight`):**
  - EMPTY: `cap` → ONE.
  - ONE: `pop && !cap` → EMPTY; `!pop && cap` → TWO; otherwise stay in ONE.
  - TWO: `pop` → ONE.
- **Ordering:** strict FIFO order; no word is dropped or duplicated.
- **Output stability:** `out_data` stays stable while `out_valid && !out_ready`.
- **Reset (including mid-operation):**
  - State goes to EMPTY, `inflight`=0, and `head`/`skid` are cleared to 0.
  - A word returning from a read issued in the cycle `rst` was asserted is discarded.
  - The FIFO is expected to be reset in the same domain.

## Timing
- **Reset values:** `fifo_read`=0, `out_valid`=0, `out_data`=0.
- **Latency:** `fifo_read` in cycle N gives `fifo_dout` valid in N+1, captured at the end of N+1, so `out_valid` is first asserted in N+2.
  - If `fifo_empty` falls in cycle T while the buffer is empty, `out_valid`=1 from T+2.
- **Throughput:** with `out_ready` held at 1 and the FIFO non-empty, one word per cycle after the initial 2-cycle fill.
- **Path types:**
  - `out_valid` and `out_data` are registered.
  - `fifo_read` is combinational from state, `inflight`, `fifo_empty` and `out_ready`. This is the only input-to-output path.
- **Back-pressure:** with `out_ready`=0, at most 2 reads are issued before `fifo_read` stays 0.

## Structure
- No shared package needed. The EMPTY/ONE/TWO state encoding is a local 2-bit localparam set.
- Single module with no sub-modules. `head`/`skid` live in one always block; the state and `inflight` register live in another.
- Bench reuses the existing `queue` scoreboard model for expected-data checking.

## Test plan
- **Reset:** hold `rst`=1 for 5 cycles with the FIFO non-empty → `fifo_read`=0, `out_valid`=0, `out_data`=0 throughout.
- **Streaming:** load words 0..15, `out_ready`=1 constant → `out_valid` first at T+2, then `out_data`=0..15 on consecutive cycles with no bubbles.
- **Back-pressure:** FIFO holds 0..7, `out_ready`=0 → exactly 2 `fifo_read` pulses and `out_data`=0 held stable. Release `out_ready` → 0..7 in order, no loss or duplication.
- **Random handshake:** random `out_ready` (50%) and random FIFO fill over 1000 words → scoreboard matches every word; `fifo_read` is never asserted with `fifo_empty`=1.
- **Drain:** FIFO goes empty after word 3 while `out_ready`=1 → words 0..3 delivered, then `out_valid`=0. Refill with 4 → `out_data`=4 appears 2 cycles after `fifo_empty` falls.
- **Reset mid-operation:** assert `rst` in the cycle after a `fifo_read` (`inflight`=1) → next cycle `out_valid`=0 and the returned word is never presented. After reset, the next pushed word is the first delivered.

Source files
------------

// File: rtl/fifo_fwft_adapter.sv
// Drains a standard-read FIFO (one-cycle read latency) and presents the words
// as a first-word-fall-through valid/ready stream through a two-entry buffer.
module fifo_fwft_adapter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fifo_read,
  input  logic [DWIDTH-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic              inflight_reg;
  logic              valid_reg;
  logic [DWIDTH-1:0] head_reg;
  logic [DWIDTH-1:0] skid_reg;
  logic              pop;
  logic              cap;
  logic [2:0]        pending;

  assign pop = valid_reg && out_ready;
  assign cap = inflight_reg;

  // Words held plus the one on its way, less the one leaving this cycle;
  // a new read is allowed only while this stays below the buffer depth.
  assign pending   = {1'b0, state_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign fifo_read = !rst && !fifo_empty && (pending < 3'd2);

  assign out_valid = valid_reg;
  assign out_data  = head_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (cap) state_next = ST_ONE;
      ST_ONE: begin
        if (pop && !cap)      state_next = ST_EMPTY;
        else if (!pop && cap) state_next = ST_TWO;
      end
      ST_TWO:   if (pop) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      inflight_reg <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_read;
      valid_reg    <= (state_next != ST_EMPTY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else begin
      case (state_reg)
        ST_EMPTY: if (cap) head_reg <= fifo_dout;
        ST_ONE: begin
          if (cap && pop)  head_reg <= fifo_dout;
          else if (cap)    skid_reg <= fifo_dout;
        end
        ST_TWO:   if (pop) head_reg <= skid_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Bench for fifo_fwft_adapter: behavioural FIFO on the read side, a
// word-availability model checked every cycle, and directed literal checks.
module tb_fifo_fwft_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_read;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  fifo_fwft_adapter #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_read (fifo_read),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] fifo_q[$];   // contents of the emulated FIFO
  logic [31:0] sb_q[$];     // words pushed, not yet read (model side)
  logic [31:0] acc_data[$]; // accepted words, for literal checks
  int          acc_cyc[$];
  int          rd_log[$];

  typedef struct {
    logic [31:0] w;
    int          avail;
  } ent_t;
  ent_t mbuf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a word read in cycle c may be presented from c+2; it stays at the
  // head until accepted. Words read but not accepted occupy buffer credit.
  initial begin
    bit          rst_prev;
    bit          ev;
    bit          pop_e;
    bit          er;
    int          c;
    logic [31:0] w;
    rst_prev = 1'b1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      c     = cyc;
      ev    = (mbuf.size() > 0) && (mbuf[0].avail <= c);
      pop_e = ev && out_ready;
      er    = !rst && !fifo_empty && ((mbuf.size() - (pop_e ? 1 : 0)) < 2);
      chk("fifo_read", {31'b0, fifo_read}, {31'b0, er});
      chk("read_while_empty", {31'b0, fifo_read & fifo_empty}, 32'd0);
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (ev) chk("out_data", out_data, mbuf[0].w);
      if (rst_prev) chk("out_data_reset", out_data, 32'd0);
      if (out_valid && out_ready) begin
        acc_data.push_back(out_data);
        acc_cyc.push_back(c);
        $display("xfer cycle=%0d data=%0h", c, out_data);
      end
      if (fifo_read) rd_log.push_back(c);
      if (pop_e) void'(mbuf.pop_front());
      if (fifo_read) begin
        w = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hBAD0BAD0;
        mbuf.push_back('{w, c + 2});
      end
      if (rst) mbuf.delete();
      rst_prev = rst;
    end
  end

  task automatic tick();
    logic        rd;
    logic [31:0] d;
    @(negedge clk);
    rd = fifo_read;
    @(posedge clk);
    if (rd && fifo_q.size() > 0) d = fifo_q.pop_front();
    else                         d = 32'hDEAD0000 | 32'($urandom_range(0, 65535));
    #1;
    fifo_dout  = d;
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    acc_data.delete();
    acc_cyc.delete();
    rd_log.delete();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n = 0;
    while (acc_data.size() < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(acc_data.size()), 32'(target));
  endtask

  initial begin
    int t;
    int pushed;
    int n;
    bit stop;
    rst        = 1'b1;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = 32'd0;
    @(posedge clk);
    #1;

    // Reset held with a non-empty FIFO
    for (int i = 0; i < 4; i++) push(32'd100 + 32'(i));
    repeat (5) tick();
    chk("reset_rd_count", 32'(rd_log.size()), 32'd0);
    fifo_q.delete();
    sb_q.delete();
    fifo_empty = 1'b1;
    rst = 1'b0;
    tick();

    // Streaming 0..15, no back-pressure
    out_ready = 1'b1;
    clear_logs();
    t = cyc;
    for (int i = 0; i < 16; i++) push(32'(i));
    run_until(16, 40, "stream_count");
    if (acc_data.size() == 16) begin
      chk("stream_first_cycle", 32'(acc_cyc[0]), 32'(t + 2));
      for (int i = 0; i < 16; i++) begin
        chk("stream_data", acc_data[i], 32'(i));
        chk("stream_no_bubble", 32'(acc_cyc[i]), 32'(t + 2 + i));
      end
    end
    repeat (3) tick();

    // Back-pressure: exactly two reads, head held
    out_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 8; i++) push(32'(i));
    repeat (5) tick();
    chk("bp_valid_mid", {31'b0, out_valid}, 32'd1);
    chk("bp_data_mid", out_data, 32'd0);
    repeat (5) tick();
    chk("bp_read_count", 32'(rd_log.size()), 32'd2);
    chk("bp_data_end", out_data, 32'd0);
    out_ready = 1'b1;
    run_until(8, 40, "bp_release_count");
    if (acc_data.size() == 8)
      for (int i = 0; i < 8; i++) chk("bp_data", acc_data[i], 32'(i));
    repeat (3) tick();

    // Drain after word 3, then refill with 4
    clear_logs();
    for (int i = 0; i < 4; i++) push(32'(i));
    repeat (8) tick();
    chk("drain_count", 32'(acc_data.size()), 32'd4);
    chk("drain_valid_low", {31'b0, out_valid}, 32'd0);
    if (acc_data.size() == 4)
      for (int i = 0; i < 4; i++) chk("drain_data", acc_data[i], 32'(i));
    t = cyc;
    push(32'd4);
    run_until(5, 10, "refill_count");
    if (acc_data.size() == 5) begin
      chk("refill_data", acc_data[4], 32'd4);
      chk("refill_cycle", 32'(acc_cyc[4]), 32'(t + 2));
    end
    repeat (3) tick();

    // Random handshake and fill over 1000 words
    clear_logs();
    pushed = 0;
    n = 0;
    while (acc_data.size() < 1000 && n < 20000) begin
      if (pushed < 1000 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          if (pushed < 1000) begin
            push(32'h1000 + 32'(pushed));
            pushed++;
          end
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("random_count", 32'(acc_data.size()), 32'd1000);
    stop = 1'b0;
    for (int i = 0; i < acc_data.size() && !stop; i++) begin
      chk("random_order", acc_data[i], 32'h1000 + 32'(i));
      if (acc_data[i] !== 32'h1000 + 32'(i)) stop = 1'b1;
    end
    out_ready = 1'b1;
    repeat (4) tick();

    // Reset while a read is in flight
    out_ready = 1'b0;
    clear_logs();
    push(32'd50);
    tick();
    chk("midrst_read_issued", 32'(rd_log.size()), 32'd1);
    rst = 1'b1;
    fifo_q.delete();
    sb_q.delete();
    fifo_empty = 1'b1;
    tick();
    chk("midrst_valid_low", {31'b0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    push(32'd60);
    run_until(1, 10, "midrst_count");
    if (acc_data.size() >= 1) chk("midrst_first_word", acc_data[0], 32'd60);
    repeat (5) tick();
    chk("midrst_no_stale", 32'(acc_data.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
